key_sw_port: RTL and testbench

- Input-side counterpart to the seven-segment output path. It turns the board's raw KEY/SW pins into clean, memory-mapped values the CPU can read.
- Synchronizes and debounces every input bit.
- Detects key-press edges and holds them in sticky pending bits until the CPU reads them.
- Counts total key presses and raises an interrupt-style flag while any press is pending.

---
 rtl/key_sw_defs_pkg.sv | 14 +
 rtl/key_sw_port_debounce.sv | 50 +++++
 rtl/key_sw_port.sv | 93 +++++++++
 tb/tb_key_sw_port.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/key_sw_defs_pkg.sv
// Shared definitions for the KEY/SW input port: register map and default debounce length.
package key_sw_defs;

    typedef enum logic [1:0] {
        KSW_ADDR_SW   = 2'd0,
        KSW_ADDR_KEY  = 2'd1,
        KSW_ADDR_PEND = 2'd2,
        KSW_ADDR_CNT  = 2'd3
    } kswAddr_e;

    // 1 ms at 50 MHz
    localparam int KSW_DB_CYCLES = 50000;

endpackage

// File: rtl/key_sw_port_debounce.sv
// One input bit: two-flop synchronizer followed by a stable-count debouncer.
module debounce_bit
    import key_sw_defs::*;
#(
    parameter int CNT_W     = 16,
    parameter int DB_CYCLES = KSW_DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample that agrees with the stable level restarts the run, so short glitches never win.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign q = stable_q;

endmodule

// File: rtl/key_sw_port.sv
// Memory-mapped KEY/SW input port: debounced levels, sticky press flags,
// a wrapping press counter and a level interrupt while any press is pending.
module key_sw_port
    import key_sw_defs::*;
#(
    parameter int NKEYS     = 4,
    parameter int NSW       = 10,
    parameter int CNT_W     = 16,
    parameter int DB_CYCLES = KSW_DB_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_n,
    input  logic [NSW-1:0]   sw,
    input  logic             mread,
    input  logic [1:0]       maddr,
    output logic [15:0]      rdata,
    output logic             rvalid,
    output logic             irq
);

    logic [NKEYS-1:0] keyStable;
    logic [NSW-1:0]   swStable;
    logic [NKEYS-1:0] keyPrev_q;
    logic [NKEYS-1:0] pressEvent;
    logic [NKEYS-1:0] pending_q;
    logic [NKEYS-1:0] pending_d;
    logic [15:0]      pressCount_q;
    logic [15:0]      pressCount_d;
    logic [15:0]      rdata_q;
    logic [15:0]      rdata_d;
    logic             rvalid_q;
    logic             clearPend;

    for (genvar i = 0; i < NKEYS; i++) begin : gKey
        debounce_bit #(.CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES)) uDb (
            .clk   (clk),
            .reset (reset),
            .din   (~key_n[i]),
            .q     (keyStable[i])
        );
    end

    for (genvar i = 0; i < NSW; i++) begin : gSw
        debounce_bit #(.CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES)) uDb (
            .clk   (clk),
            .reset (reset),
            .din   (sw[i]),
            .q     (swStable[i])
        );
    end

    // A press arriving on the same edge as a pending read-clear survives: set beats clear.
    always_comb begin
        pressEvent   = keyStable & ~keyPrev_q;
        clearPend    = mread && (maddr == KSW_ADDR_PEND);
        pending_d    = (clearPend ? '0 : pending_q) | pressEvent;
        pressCount_d = pressCount_q;
        for (int i = 0; i < NKEYS; i++) begin
            pressCount_d = pressCount_d + 16'(pressEvent[i]);
        end
        rdata_d = rdata_q;
        if (mread) begin
            case (maddr)
                KSW_ADDR_SW:   rdata_d = 16'(swStable);
                KSW_ADDR_KEY:  rdata_d = 16'(keyStable);
                KSW_ADDR_PEND: rdata_d = 16'(pending_q);
                KSW_ADDR_CNT:  rdata_d = pressCount_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keyPrev_q    <= '0;
            pending_q    <= '0;
            pressCount_q <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            keyPrev_q    <= keyStable;
            pending_q    <= pending_d;
            pressCount_q <= pressCount_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= mread;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign irq    = |pending_q;

endmodule

// File: tb/tb_key_sw_port.sv
// Directed bench for key_sw_port with a short debounce (4 samples) so latencies stay small.
module tb_key_sw_port;

    logic        clk;
    logic        reset;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic        mread;
    logic [1:0]  maddr;
    logic [15:0] rdata;
    logic        rvalid;
    logic        irq;

    int checks;
    int failures;

    typedef struct {
        logic [9:0]  sw;
        logic [1:0]  addr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    key_sw_port #(.NKEYS(4), .NSW(10), .CNT_W(16), .DB_CYCLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_n),
        .sw     (sw),
        .mread  (mread),
        .maddr  (maddr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] k, input logic [9:0] s);
        key_n = k;
        sw    = s;
    endtask

    task automatic doRead(input logic [1:0] a, input logic [15:0] e, input string name);
        maddr = a;
        mread = 1'b1;
        tick();
        mread = 1'b0;
        checkOutput({name, " rvalid"}, 16'(rvalid), 16'h0001);
        checkOutput(name, rdata, e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{sw: 10'h3FF, addr: 2'd0, exp: 16'h03FF};
        vecs[1] = '{sw: 10'h155, addr: 2'd0, exp: 16'h0155};
        vecs[2] = '{sw: 10'h2AA, addr: 2'd0, exp: 16'h02AA};
        vecs[3] = '{sw: 10'h000, addr: 2'd0, exp: 16'h0000};
        vecs[4] = '{sw: 10'h2A5, addr: 2'd3, exp: 16'h0001};
        vecs[5] = '{sw: 10'h2A5, addr: 2'd2, exp: 16'h0000};

        reset = 1'b0;
        mread = 1'b0;
        maddr = 2'd0;
        applyStimulus(4'hF, 10'h000);
        tick(3);
        checkOutput("reset rdata", rdata, 16'h0000);
        checkOutput("reset rvalid", 16'(rvalid), 16'h0000);
        checkOutput("reset irq", 16'(irq), 16'h0000);
        reset = 1'b1;
        tick(2);

        // Press key 2 while reading the key register every cycle to pin down the latency.
        key_n[2] = 1'b0;
        maddr    = 2'd1;
        mread    = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checkOutput($sformatf("press lat rvalid c%0d", k), 16'(rvalid), 16'h0001);
            checkOutput($sformatf("press lat keys c%0d", k), rdata, (k == 7) ? 16'h0004 : 16'h0000);
            checkOutput($sformatf("press lat irq c%0d", k), 16'(irq), (k == 7) ? 16'h0001 : 16'h0000);
        end
        mread = 1'b0;
        tick(3);
        key_n[2] = 1'b1;
        tick(8);
        checkOutput("irq after press", 16'(irq), 16'h0001);
        doRead(2'd3, 16'h0001, "count after press");
        doRead(2'd2, 16'h0004, "pending read");
        checkOutput("irq after clear", 16'(irq), 16'h0000);
        doRead(2'd2, 16'h0000, "pending cleared");

        // Three-sample glitch on key 0 must be rejected.
        key_n[0] = 1'b0;
        tick(3);
        key_n[0] = 1'b1;
        tick(10);
        doRead(2'd1, 16'h0000, "glitch keys");
        doRead(2'd2, 16'h0000, "glitch pending");
        doRead(2'd3, 16'h0001, "glitch count");
        checkOutput("glitch irq", 16'(irq), 16'h0000);

        // Back-to-back reads.
        sw = 10'h2A5;
        tick(6);
        mread = 1'b1;
        maddr = 2'd0;
        tick();
        checkOutput("pipe0 rvalid", 16'(rvalid), 16'h0001);
        checkOutput("pipe0 rdata", rdata, 16'h02A5);
        maddr = 2'd1;
        tick();
        checkOutput("pipe1 rvalid", 16'(rvalid), 16'h0001);
        checkOutput("pipe1 rdata", rdata, 16'h0000);
        maddr = 2'd3;
        tick();
        checkOutput("pipe2 rvalid", 16'(rvalid), 16'h0001);
        checkOutput("pipe2 rdata", rdata, 16'h0001);
        mread = 1'b0;
        tick();
        checkOutput("idle rvalid", 16'(rvalid), 16'h0000);
        checkOutput("idle rdata hold", rdata, 16'h0001);

        for (int v = 0; v < 6; v++) begin
            sw = vecs[v].sw;
            tick(7);
            doRead(vecs[v].addr, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Key 1 becomes stable exactly on the edge that samples a pending read.
        key_n[0] = 1'b0;
        tick(8);
        checkOutput("race pre irq", 16'(irq), 16'h0001);
        key_n[1] = 1'b0;
        tick(6);
        doRead(2'd2, 16'h0001, "race old pending");
        checkOutput("race irq held", 16'(irq), 16'h0001);
        doRead(2'd2, 16'h0002, "race new pending");
        checkOutput("race irq cleared", 16'(irq), 16'h0000);
        key_n = 4'hF;
        tick(8);
        doRead(2'd3, 16'h0003, "race count");

        // Counter wrap from a preloaded 0xFFFF.
        force dut.pressCount_q = 16'hFFFF;
        tick();
        release dut.pressCount_q;
        doRead(2'd3, 16'hFFFF, "preload count");
        key_n[3] = 1'b0;
        tick(8);
        doRead(2'd3, 16'h0000, "wrap count");
        doRead(2'd2, 16'h0008, "wrap pending");
        key_n = 4'hF;
        tick(8);

        key_n = 4'b1010;
        tick(8);
        doRead(2'd3, 16'h0002, "dual press count");
        doRead(2'd2, 16'h0005, "dual press pending");
        key_n = 4'hF;
        tick(8);

        // Reset arrives mid-debounce and while a read result is on the bus.
        sw = 10'h3FF;
        key_n = 4'b1011;
        tick(8);
        key_n = 4'b1001;
        tick(3);
        maddr = 2'd3;
        mread = 1'b1;
        tick();
        mread = 1'b0;
        checkOutput("pre-reset rvalid", 16'(rvalid), 16'h0001);
        checkOutput("pre-reset rdata", rdata, 16'h0003);
        checkOutput("pre-reset irq", 16'(irq), 16'h0001);
        reset = 1'b0;
        key_n = 4'hF;
        #1;
        checkOutput("async rvalid", 16'(rvalid), 16'h0000);
        checkOutput("async rdata", rdata, 16'h0000);
        checkOutput("async irq", 16'(irq), 16'h0000);
        tick(2);
        reset = 1'b1;
        doRead(2'd0, 16'h0000, "post-reset sw early");
        tick(6);
        doRead(2'd0, 16'h03FF, "post-reset sw settled");
        doRead(2'd3, 16'h0000, "post-reset count");
        doRead(2'd2, 16'h0000, "post-reset pending");
        doRead(2'd1, 16'h0000, "post-reset keys");
        checkOutput("post-reset irq", 16'(irq), 16'h0000);
        tick();
        checkOutput("post-reset rvalid idle", 16'(rvalid), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
